// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: counter widths,
// saturation limit and the idle line level.
package uart_rx_pkg;

    localparam int PRESCALE_W = 5;
    localparam int BIT_CNT_W  = 4;

    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 4'd15;

    localparam logic LINE_IDLE = 1'b1;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Flop-chain synchroniser for the raw serial line,
// reset to the idle level so no false start is seen.
module rx_sync
    import uart_rx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // shift the line through the chain, oldest at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{LINE_IDLE}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/edge_bit_sampler.sv
// UART RX timing stage: edge/bit counters, three
// mid-bit samples and a majority vote per bit.
module edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  counter_en,
    input  logic                  data_samp_en,
    output logic                  RX_sync,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  samp_valid
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [2:0]            smp_q, smp_d;
    logic [1:0]            arm_q, arm_d;
    logic                  sbit_q, sbit_d;
    logic                  valid_q, valid_d;

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid;
    logic                  hit0, hit1, hit2;

    rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (RX_in),
        .q_o   (RX_sync)
    );

    assign last_edge = prescale - PRESCALE_W'(1);
    assign mid       = prescale >> 1;
    assign hit0      = (edge_q == mid - PRESCALE_W'(1));
    assign hit1      = (edge_q == mid);
    assign hit2      = (edge_q == mid + PRESCALE_W'(1));

    // wrap with >= so a shrunken prescale still ends the bit;
    // a disabled counter always clears both counts
    always_comb begin
        edge_d = '0;
        bit_d  = '0;
        if (counter_en) begin
            if (edge_q >= last_edge) begin
                edge_d = '0;
                bit_d  = (bit_q == BIT_CNT_MAX) ? bit_q
                                                : bit_q + 1'b1;
            end else begin
                edge_d = edge_q + 1'b1;
                bit_d  = bit_q;
            end
        end
    end

    // arm flags remember that the earlier samples were taken;
    // the vote uses the live line for the third sample
    always_comb begin
        smp_d   = smp_q;
        arm_d   = arm_q;
        sbit_d  = sbit_q;
        valid_d = 1'b0;
        if (hit0) begin
            arm_d[0] = data_samp_en;
            if (data_samp_en) smp_d[0] = RX_sync;
        end
        if (hit1) begin
            arm_d[1] = arm_q[0] & data_samp_en;
            if (data_samp_en) smp_d[1] = RX_sync;
        end
        if (hit2 && data_samp_en) begin
            smp_d[2] = RX_sync;
            if (arm_q[1]) begin
                sbit_d  = maj3(smp_q[0], smp_q[1], RX_sync);
                valid_d = 1'b1;
            end
        end
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q  <= '0;
            bit_q   <= '0;
            smp_q   <= {3{LINE_IDLE}};
            arm_q   <= '0;
            sbit_q  <= LINE_IDLE;
            valid_q <= 1'b0;
        end else begin
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            arm_q   <= arm_d;
            sbit_q  <= sbit_d;
            valid_q <= valid_d;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign sampled_bit = sbit_q;
    assign samp_valid  = valid_q;

endmodule

// File: tb/tb_edge_bit_sampler.sv
// Directed and random bench for edge_bit_sampler
// against a run-length based reference model.
module tb_edge_bit_sampler;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_in;
    logic [4:0] prescale;
    logic       counter_en;
    logic       data_samp_en;
    logic       RX_sync;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       samp_valid;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_cnt;
    bit m_syncq[$];
    bit m_sb;
    bit m_sv;
    int m_pe[2];
    bit m_pr[2];
    bit m_pd[2];
    int m_h;

    // values seen at the last check point
    logic       obs_rx;
    logic [4:0] obs_edge;
    logic [3:0] obs_bit;
    logic       obs_sb;
    logic       obs_valid;

    edge_bit_sampler #(
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_in        (RX_in),
        .prescale     (prescale),
        .counter_en   (counter_en),
        .data_samp_en (data_samp_en),
        .RX_sync      (RX_sync),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .samp_valid   (samp_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_syncq.delete();
        repeat (SYNC) m_syncq.push_back(1'b1);
        m_sb = 1'b1;
        m_sv = 1'b0;
        m_h  = 0;
    endtask

    // one clock of the spec: counts are the enabled run length
    // split into bit periods; a vote needs three consecutive
    // enabled samples ending at mid+1
    task automatic model_step();
        int pp;
        int e;
        int m;
        bit rs;
        bit nv;
        if (!rst) begin
            model_reset();
        end else begin
            pp = int'(prescale);
            e  = m_cnt % pp;
            m  = pp / 2;
            rs = m_syncq[0];
            nv = 1'b0;
            if (e == m + 1 && data_samp_en && m_h >= 2 &&
                m_pe[1] == m && m_pe[0] == m - 1 &&
                m_pd[0] && m_pd[1]) begin
                m_sb = (int'(m_pr[0]) + int'(m_pr[1])
                        + int'(rs)) >= 2;
                nv = 1'b1;
            end
            m_sv = nv;
            m_pe[0] = m_pe[1];
            m_pe[1] = e;
            m_pr[0] = m_pr[1];
            m_pr[1] = rs;
            m_pd[0] = m_pd[1];
            m_pd[1] = data_samp_en;
            m_h++;
            m_cnt = counter_en ? m_cnt + 1 : 0;
            m_syncq.push_back(RX_in);
            void'(m_syncq.pop_front());
        end
    endtask

    task automatic check_all();
        int pp;
        int eb;
        pp = int'(prescale);
        eb = m_cnt / pp;
        if (eb > 15) eb = 15;
        obs_rx    = RX_sync;
        obs_edge  = edge_cnt;
        obs_bit   = bit_cnt;
        obs_sb    = sampled_bit;
        obs_valid = samp_valid;
        chk("rx_sync", obs_rx, m_syncq[0]);
        chk("edge_cnt", obs_edge, m_cnt % pp);
        chk("bit_cnt", obs_bit, eb);
        chk("sampled_bit", obs_sb, m_sb);
        chk("samp_valid", obs_valid, m_sv);
    endtask

    task automatic cycle(input logic rx,
                         input logic ce,
                         input logic dse);
        RX_in        = rx;
        counter_en   = ce;
        data_samp_en = dse;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle2(input int newp);
        cycle(1'b1, 1'b0, 1'b0);
        prescale = 5'(newp);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        int len;
        int mode;
        logic [9:0] frame;
        logic [9:0] got;
        logic dse;

        rst          = 1'b0;
        RX_in        = 1'b1;
        prescale     = 5'd8;
        counter_en   = 1'b0;
        data_samp_en = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // reset held with a toggling line
        for (int i = 0; i < 6; i++) begin
            cycle(i[0], 1'b1, 1'b1);
            chk("rst_rx_sync", obs_rx, 1);
            chk("rst_sampled", obs_sb, 1);
        end
        rst = 1'b1;

        // prescale 8, 80 enabled cycles
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            if (obs_valid) begin
                pulses++;
                chk("p8_valid_edge", obs_edge, 6);
            end
        end
        cycle(1'b1, 1'b0, 1'b1);
        chk("p8_bit_cnt_10", obs_bit, 10);
        chk("p8_pulses", pulses, 10);

        // prescale 16, frame 0x55 with start and stop
        idle2(16);
        frame = {1'b1, 8'h55, 1'b0};
        got = '1;
        pulses = 0;
        for (int i = 0; i < 160; i++) begin
            cycle(frame[i / 16], 1'b1, 1'b1);
            if (obs_valid) begin
                chk("p16_valid_edge", obs_edge, 10);
                if (pulses < 10) got[pulses] = obs_sb;
                pulses++;
            end
        end
        chk("p16_pulses", pulses, 10);
        chk("p16_sequence", got, frame);

        // majority vote: 1,0,1 then 0,0,1
        idle2(8);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) cycle((i % 8) != 2, 1'b1, 1'b1);
            else cycle((i % 8) != 1 && (i % 8) != 2,
                       1'b1, 1'b1);
            if (obs_valid) begin
                if (pulses == 0) chk("vote_101", obs_sb, 1);
                else chk("vote_001", obs_sb, 0);
                pulses++;
            end
        end
        chk("vote_pulses", pulses, 2);

        // saturation then clear on a wrap
        idle2(8);
        for (int i = 0; i < 160; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1,
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 7; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            if (i == 0) chk("sat_bit_15", obs_bit, 15);
        end
        cycle(1'b1, 1'b0, 1'b1);
        chk("clr_at_wrap_edge", obs_edge, 7);
        chk("clr_at_wrap_bit", obs_bit, 15);
        cycle(1'b1, 1'b0, 1'b1);
        chk("clr_edge_0", obs_edge, 0);
        chk("clr_bit_0", obs_bit, 0);

        // asynchronous reset mid-frame
        idle2(8);
        for (int i = 0; i < 37; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        chk("mrst_pre_edge", edge_cnt, 5);
        chk("mrst_pre_bit", bit_cnt, 4);
        rst = 1'b0;
        #1;
        chk("mrst_rx_sync", RX_sync, 1);
        chk("mrst_edge", edge_cnt, 0);
        chk("mrst_bit", bit_cnt, 0);
        chk("mrst_sampled", sampled_bit, 1);
        chk("mrst_valid", samp_valid, 0);
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            if (i < 7) chk("mrst_first_vote", obs_valid, i == 6);
        end

        // random prescale, line and sample enables
        for (int r = 0; r < 6; r++) begin
            idle2($urandom_range(6, 31));
            len  = $urandom_range(20, 300);
            mode = r % 3;
            for (int i = 0; i < len; i++) begin
                if (mode == 0) dse = 1'b1;
                else if (mode == 1) dse = 1'($urandom_range(0, 1));
                else dse = 1'($urandom_range(0, 7) != 0);
                cycle(1'($urandom_range(0, 1)), 1'b1, dse);
            end
        end
        cycle(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
